mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequences the single shared RAM port between the instruction-fetch requester and the data requester (load/store traffic decoded by the control unit). It grants one requester at a time, drives the RAM request, returns read data and holds the requester in wait until the RAM reports completion. Data requests have priority, with a bounded-streak rule that prevents fetch starvation. It sits between the datapath/caches and the RAM model.

## Interface
- MAX_DSTREAK, 4, consecutive data grants allowed while iREN is pending before fetch is forced (must be ≥1)
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  instruction read request, held until iwait low
- iaddr  in  32  fetch address
- dREN  in  1  data read request, held until dwait low
- dWEN  in  1  data write request, held until dwait low
- daddr  in  32  data address
- dstore  in  32  write data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- ramload  in  32  RAM read data
- iwait  out  1  fetch stall
- dwait  out  1  data stall
- iload  out  32  fetch data
- dload  out  32  load data
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- err  out  1  sticky RAM error flag

## Operation
- States: IDLE, IGNT, DGNT; state register, streak counter and err are the only flops.
- dreq = dREN | dWEN; dWEN with dREN is a write (WEN wins).
- IDLE → DGNT if dreq and (!iREN or streak < MAX_DSTREAK); else IGNT if iREN; else stay.
- IGNT: ramaddr=iaddr, ramREN=1, ramWEN=0. DGNT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&!dWEN.
- done = ramstate ∈ {ACCESS, ERROR} while in a grant state. Grant state → IDLE on done; otherwise hold (FREE/BUSY = stall).
- iwait = iREN & !(state==IGNT & done); dwait = dreq & !(state==DGNT & done).
- iload = ramload when state==IGNT & ramstate==ACCESS, else 0; dload likewise for DGNT with read. On ERROR, load data = 0.
- Streak: on entering DGNT while iREN=1, streak += 1 (saturating at MAX_DSTREAK); on entering IGNT, streak = 0; on entering DGNT with iREN=0, streak = 0.
- err sets on any done with ramstate==ERROR; cleared only by RST.
- Requests dropped mid-grant (protocol violation): grant state still completes on done; results discarded.

## Timing
- Reset (RST high at edge): state IDLE, streak 0, err 0. Outputs after reset: ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0, iwait=iREN, dwait=dreq (combinational).
- RST mid-transaction aborts: next cycle IDLE, RAM strobes low, no data returned.
- Request seen in IDLE at edge N → grant state and RAM strobes from cycle N+1. Minimum request-to-wait-low: 2 cycles (RAM ACCESS in first grant cycle).
- Wait low for exactly one cycle per transaction; load data valid in that same cycle.
- After completion, one mandatory IDLE cycle (the completed requester sees wait low and updates its request first); back-to-back grants are spaced ≥2 cycles apart.
- Simultaneous iREN and dreq in IDLE: data wins unless streak == MAX_DSTREAK.
- Address/data inputs must be stable while the corresponding wait is high; outputs pass them combinationally.

## Test plan
- Reset: assert RST with iREN=1 → ramREN=0, iwait=1, err=0, state IDLE next cycle.
- Single fetch, iaddr=0x40, RAM ACCESS on first grant cycle with ramload=0x3C010001 → ramREN high cycle 1, iwait low cycle 1, iload=0x3C010001, IDLE cycle 2.
- Store daddr=0x100, dstore=0xDEADBEEF, RAM BUSY 3 cycles then ACCESS → ramWEN held 4 cycles with stable address/data, dwait low only on ACCESS cycle.
- Contention, MAX_DSTREAK=4, iREN and dREN held continuously, RAM always ACCESS → grant order D,D,D,D,I,D,D,D,D,I; no fetch waits more than 5 grants.
- RAM returns ERROR on a load → dwait low one cycle, dload=0, err=1 and remains 1 until RST.
- RST asserted during DGNT with RAM BUSY → next cycle ramREN=ramWEN=0, dwait=dreq, streak 0; re-request then completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between instruction fetch and data
// load/store traffic. Data requests have priority. After MAX_DSTREAK data
// grants in a row while a fetch waits, the fetch is granted next.
//
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   iREN, iaddr         fetch request and address (held until iwait low)
//   dREN, dWEN, daddr,  data read/write request, address and store data
//   dstore              (held until dwait low; WEN wins over REN)
//   ramstate, ramload   RAM status (FREE/BUSY/ACCESS/ERROR) and read data
//   iwait, dwait        requester stalls (combinational)
//   iload, dload        returned read data, valid while the matching wait is low
//   ramaddr, ramstore,  RAM request (combinational from the granted requester)
//   ramREN, ramWEN
//   err                 sticky RAM error flag, cleared only by RST
module mem_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ramREN,
  output logic        ramWEN,
  output logic        err
);

  localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] streak, streak_n;
  logic          err_n;
  logic          dreq;
  logic          done;

  // State, streak counter and sticky error flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      streak <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      streak <= streak_n;
      err    <= err_n;
    end
  end

  // Grant selection, RAM request steering and requester handshakes
  always_comb begin
    state_n  = state;
    streak_n = streak;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    iload    = '0;
    dload    = '0;

    dreq  = dREN | dWEN;
    // ACCESS and ERROR both end a transaction; only meaningful in a grant state
    done  = (state != IDLE) && ((ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR));
    err_n = err | (done && (ramstate == RAM_ERROR));
    iwait = iREN & ~((state == IGNT) & done);
    dwait = dreq & ~((state == DGNT) & done);

    unique case (state)
      IDLE: begin
        if (dreq && (!iREN || (streak < STREAK_MAX))) begin
          state_n = DGNT;
          // Only count data grants that actually make a fetch wait
          if (iREN) begin
            streak_n = (streak == STREAK_MAX) ? streak : streak + SW'(1);
          end else begin
            streak_n = '0;
          end
        end else if (iREN) begin
          state_n  = IGNT;
          streak_n = '0;
        end
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (ramstate == RAM_ACCESS) begin
          iload = ramload;
        end
        if (done) begin
          state_n = IDLE;
        end
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if ((ramstate == RAM_ACCESS) && dREN && !dWEN) begin
          dload = ramload;
        end
        if (done) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized
// requester/RAM traffic, all compared cycle by cycle against a
// transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam int unsigned MAXD = 4;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [1:0]  ramstate;
  logic [31:0] ramload;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        ramREN;
  logic        ramWEN;
  logic        err;

  mem_arbiter #(.MAX_DSTREAK(MAXD)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .ramstate (ramstate),
    .ramload  (ramload),
    .iwait    (iwait),
    .dwait    (dwait),
    .iload    (iload),
    .dload    (dload),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .err      (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the RAM port (0 nobody, 1 fetch, 2 data),
  // how many data grants in a row have overtaken a waiting fetch, error flag.
  int owner = 0;
  int drun  = 0;
  bit merr  = 1'b0;

  // Expected waits of the current cycle, used by the requester agents
  bit e_iwait;
  bit e_dwait;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic bit finishing();
    return (owner != 0) && (ramstate == 2'd2 || ramstate == 2'd3);
  endfunction

  // Mid-cycle: let inputs settle, compare every output against the model
  task automatic settle();
    bit          fin;
    bit          rd;
    logic [31:0] e_addr;
    #4;
    fin = finishing();
    rd  = dREN && !dWEN;
    e_iwait = iREN && !(owner == 1 && fin);
    e_dwait = (dREN || dWEN) && !(owner == 2 && fin);
    e_addr  = (owner == 1) ? iaddr : (owner == 2) ? daddr : 32'h0;
    chk("iwait",    32'(iwait),  32'(e_iwait));
    chk("dwait",    32'(dwait),  32'(e_dwait));
    chk("ramaddr",  ramaddr,     e_addr);
    chk("ramstore", ramstore,    (owner == 2) ? dstore : 32'h0);
    chk("ramREN",   32'(ramREN), 32'((owner == 1) || (owner == 2 && rd)));
    chk("ramWEN",   32'(ramWEN), 32'(owner == 2 && dWEN));
    chk("iload",    iload,  (owner == 1 && ramstate == 2'd2) ? ramload : 32'h0);
    chk("dload",    dload,  (owner == 2 && rd && ramstate == 2'd2) ? ramload : 32'h0);
    chk("err",      32'(err),    32'(merr));
  endtask

  // Clock edge: advance the model with the inputs that were present at the edge
  task automatic tick();
    bit fin;
    @(posedge CLK);
    fin = finishing();
    if (RST) begin
      owner = 0;
      drun  = 0;
      merr  = 1'b0;
    end else if (owner != 0) begin
      if (fin) begin
        if (ramstate == 2'd3) merr = 1'b1;
        owner = 0;
      end
    end else if (dREN || dWEN) begin
      if (iREN && drun >= int'(MAXD)) begin
        owner = 1;
        drun  = 0;
      end else begin
        owner = 2;
        drun  = iREN ? ((drun + 1 > int'(MAXD)) ? int'(MAXD) : drun + 1) : 0;
      end
    end else if (iREN) begin
      owner = 1;
      drun  = 0;
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  initial begin
    logic [31:0] order;
    int          gidx;
    bit          i_act;
    bit          d_act;

    RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramstate = 2'd0; ramload = '0;
    tick();

    // Reset held with a fetch pending
    RST = 1'b1; iREN = 1'b1; iaddr = 32'h40;
    settle();
    tick();
    settle();
    chk("rst_ramREN", 32'(ramREN), 32'h0);
    chk("rst_iwait",  32'(iwait),  32'h1);
    chk("rst_err",    32'(err),    32'h0);

    // Single fetch completing on the first grant cycle
    RST = 1'b0;
    tick();
    ramstate = 2'd2; ramload = 32'h3C010001;
    settle();
    chk("fetch_ramREN", 32'(ramREN), 32'h1);
    chk("fetch_iwait",  32'(iwait),  32'h0);
    chk("fetch_iload",  iload,       32'h3C010001);
    tick();
    iREN = 1'b0;
    settle();
    chk("fetch_idle_ramREN", 32'(ramREN), 32'h0);
    tick();

    // Store with three BUSY cycles before ACCESS
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = 2'd1;
    cycle();
    for (int k = 0; k < 4; k++) begin
      ramstate = (k == 3) ? 2'd2 : 2'd1;
      settle();
      chk("store_ramWEN",   32'(ramWEN), 32'h1);
      chk("store_ramaddr",  ramaddr,     32'h100);
      chk("store_ramstore", ramstore,    32'hDEADBEEF);
      chk("store_dwait",    32'(dwait),  (k == 3) ? 32'h0 : 32'h1);
      tick();
    end
    dWEN = 1'b0; ramstate = 2'd0;
    cycle();

    // Contention with both requests held and the RAM always ready
    iREN = 1'b1; dREN = 1'b1; ramstate = 2'd2; order = '0; gidx = 0;
    for (int k = 0; k < 20; k++) begin
      ramload = $urandom;
      settle();
      if (iwait === 1'b0 && gidx < 32) begin order[gidx] = 1'b1; gidx++; end
      else if (dwait === 1'b0 && gidx < 32) gidx++;
      tick();
    end
    chk("grant_count", 32'(gidx), 32'd10);
    chk("grant_order", order, 32'h210);
    iREN = 1'b0; dREN = 1'b0; ramstate = 2'd0;
    cycle();

    // Load answered with ERROR
    dREN = 1'b1; daddr = 32'h200;
    cycle();
    ramstate = 2'd3; ramload = 32'hFFFF_FFFF;
    settle();
    chk("errld_dwait", 32'(dwait), 32'h0);
    chk("errld_dload", dload,      32'h0);
    tick();
    dREN = 1'b0; ramstate = 2'd0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("err_sticky", 32'(err), 32'h1);
      tick();
    end

    // Reset in the middle of a BUSY data grant, then re-request
    dREN = 1'b1; daddr = 32'h300; ramstate = 2'd1;
    cycle();
    RST = 1'b1;
    settle();
    chk("abort_pre_ramREN", 32'(ramREN), 32'h1);
    tick();
    RST = 1'b0;
    settle();
    chk("abort_ramREN", 32'(ramREN), 32'h0);
    chk("abort_ramWEN", 32'(ramWEN), 32'h0);
    chk("abort_dwait",  32'(dwait),  32'h1);
    chk("abort_err",    32'(err),    32'h0);
    tick();
    ramstate = 2'd2; ramload = 32'h1234_5678;
    settle();
    chk("rereq_dwait", 32'(dwait), 32'h0);
    chk("rereq_dload", dload,      32'h1234_5678);
    tick();
    dREN = 1'b0;
    cycle();

    // Randomized traffic from protocol-abiding requesters
    i_act = 1'b0; d_act = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      int r;
      RST = ($urandom_range(0, 99) < 2);
      if (i_act && !iREN) i_act = 1'b0;
      if (!i_act && ($urandom_range(0, 1) == 1)) begin
        i_act = 1'b1; iREN = 1'b1; iaddr = $urandom;
      end else if (!i_act) begin
        iREN = 1'b0;
      end
      if (!d_act && ($urandom_range(0, 1) == 1)) begin
        d_act = 1'b1;
        r = int'($urandom_range(0, 3));
        dREN = (r != 1); dWEN = (r != 0);
        daddr = $urandom; dstore = $urandom;
      end else if (!d_act) begin
        dREN = 1'b0; dWEN = 1'b0;
      end
      r = int'($urandom_range(0, 9));
      ramstate = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      ramload = $urandom;
      settle();
      tick();
      // A requester whose wait dropped this cycle has finished
      if (i_act && !e_iwait) begin i_act = 1'b0; iREN = 1'b0; end
      if (d_act && !e_dwait) begin d_act = 1'b0; dREN = 1'b0; dWEN = 1'b0; end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
